// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture: trace capture and run control for the single-cycle
// RISC-V core. It samples PC, ALU result, r_out and the memory strobes into a
// circular buffer. A run ends on a programme halt (PC stuck for HALT_REPEAT
// captures) or when the cycle budget is used up. Afterwards the buffer can be
// read back by index, with index 0 being the oldest retained entry.
// Optional feature macro: TRACE_MEM_FILTER_EN. When it is defined, only RUN
// edges that carry a memory strobe are stored in the buffer.
module riscv_trace_capture #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH       = 64,
  parameter int unsigned MAX_CYCLES  = 40,
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          alu_i,
  input  logic [XLEN-1:0]          rout_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_alu,
  output logic [XLEN-1:0]          rd_rout,
  output logic [1:0]               rd_flags,
  output logic [1:0]               state_o,
  output logic                     done,
  output logic                     halted,
  output logic                     timeout,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   entries,
  output logic [31:0]              cycle_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state, w_state_nxt;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_entries;
  logic [31:0]       r_cycle;
  logic [31:0]       r_rep;
  logic [XLEN-1:0]   r_prev_pc;
  logic              r_halted, r_timeout, r_overflow;

  logic [XLEN-1:0]   r_mem_pc   [DEPTH];
  logic [XLEN-1:0]   r_mem_alu  [DEPTH];
  logic [XLEN-1:0]   r_mem_rout [DEPTH];
  logic [1:0]        r_mem_fl   [DEPTH];

  logic              r_rd_valid;
  logic [XLEN-1:0]   r_rd_pc, r_rd_alu, r_rd_rout;
  logic [1:0]        r_rd_fl;

  logic              w_run, w_start_acc, w_store, w_rd_acc, w_rd_oob;
  logic              w_halt_hit, w_budget_hit;
  logic [31:0]       w_rep_nxt, w_cyc_nxt;
  logic [AW-1:0]     w_rd_addr;

  assign w_run       = (r_state == S_RUN);
  assign w_start_acc = start && !w_run;
  assign w_rd_acc    = rd_req && !w_run;

`ifdef TRACE_MEM_FILTER_EN
  assign w_store = w_run && (mem_read_i || mem_write_i);
`else
  assign w_store = w_run;
`endif

  // The first capture of a run starts a new repeat streak. Later captures
  // extend the streak only while the PC stays the same.
  assign w_rep_nxt    = (r_cycle == 32'd0 || pc_i != r_prev_pc) ? 32'd1 : r_rep + 32'd1;
  assign w_cyc_nxt    = r_cycle + 32'd1;
  assign w_halt_hit   = w_run && (w_rep_nxt == HALT_REPEAT);
  assign w_budget_hit = w_run && (w_cyc_nxt == MAX_CYCLES);

  // Index 0 maps to the oldest retained entry. When the buffer is full the
  // subtraction leaves the write pointer unchanged, and that is the oldest slot.
  assign w_rd_addr = r_wr_ptr - r_entries[AW-1:0] + rd_idx;
  assign w_rd_oob  = ({1'b0, rd_idx} >= r_entries);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start is honoured outside RUN, and halt or budget ends a run
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt_hit || w_budget_hit) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping: pointers, counters and sticky status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_entries  <= '0;
      r_cycle    <= '0;
      r_rep      <= '0;
      r_prev_pc  <= '0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_acc) begin
      r_wr_ptr   <= '0;
      r_entries  <= '0;
      r_cycle    <= '0;
      r_rep      <= '0;
      r_halted   <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_run) begin
      r_cycle   <= w_cyc_nxt;
      r_rep     <= w_rep_nxt;
      r_prev_pc <= pc_i;
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_entries == FULL) r_overflow <= 1'b1;
        else                   r_entries  <= r_entries + 1'b1;
      end
      if (w_halt_hit)   r_halted  <= 1'b1;
      if (w_budget_hit) r_timeout <= 1'b1;
    end
  end

  // Trace storage. Contents do not matter after reset, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_pc[r_wr_ptr]   <= pc_i;
      r_mem_alu[r_wr_ptr]  <= alu_i;
      r_mem_rout[r_wr_ptr] <= rout_i;
      r_mem_fl[r_wr_ptr]   <= {mem_write_i, mem_read_i};
    end
  end

  // Registered readback: one result per accepted request, zero data past the fill level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_alu   <= '0;
      r_rd_rout  <= '0;
      r_rd_fl    <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_pc   <= w_rd_oob ? '0 : r_mem_pc[w_rd_addr];
        r_rd_alu  <= w_rd_oob ? '0 : r_mem_alu[w_rd_addr];
        r_rd_rout <= w_rd_oob ? '0 : r_mem_rout[w_rd_addr];
        r_rd_fl   <= w_rd_oob ? '0 : r_mem_fl[w_rd_addr];
      end
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_pc       = r_rd_pc;
  assign rd_alu      = r_rd_alu;
  assign rd_rout     = r_rd_rout;
  assign rd_flags    = r_rd_fl;
  assign state_o     = r_state;
  assign done        = (r_state == S_DONE);
  assign halted      = r_halted;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign entries     = r_entries;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_riscv_trace_capture.sv
// Bench for riscv_trace_capture. A queue-based reference model runs beside the
// DUT and the outputs are compared against it on every cycle. Literal checks
// pin the reference values for each scenario.
module tb_riscv_trace_capture;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int MAXC  = 40;
  localparam int HR    = 4;
`ifdef TRACE_MEM_FILTER_EN
  localparam bit STORE_ALL = 1'b0;
`else
  localparam bit STORE_ALL = 1'b1;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start4 = 1'b0;
  logic mem_read_i = 1'b0, mem_write_i = 1'b0, rd_req = 1'b0;
  logic [31:0] pc_i = '0, alu_i = '0, rout_i = '0;
  logic [AW-1:0] rd_idx = '0;

  logic        rd_valid, done, halted, timeout, overflow;
  logic [31:0] rd_pc, rd_alu, rd_rout, cycle_count;
  logic [1:0]  rd_flags, state_o;
  logic [AW:0] entries;

  logic        rd_valid4, done4, halted4, timeout4, overflow4;
  logic [31:0] rd_pc4, rd_alu4, rd_rout4, cycle_count4;
  logic [1:0]  rd_flags4, state4;
  logic [AW:0] entries4;

  riscv_trace_capture #(.XLEN(32), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(HR)) dut (
    .clk(clk), .reset(reset), .start(start), .pc_i(pc_i), .alu_i(alu_i), .rout_i(rout_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_alu(rd_alu), .rd_rout(rd_rout), .rd_flags(rd_flags),
    .state_o(state_o), .done(done), .halted(halted), .timeout(timeout), .overflow(overflow),
    .entries(entries), .cycle_count(cycle_count));

  riscv_trace_capture #(.XLEN(32), .DEPTH(DEPTH), .MAX_CYCLES(4), .HALT_REPEAT(HR)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .pc_i(pc_i), .alu_i(alu_i), .rout_i(rout_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid4), .rd_pc(rd_pc4), .rd_alu(rd_alu4), .rd_rout(rd_rout4), .rd_flags(rd_flags4),
    .state_o(state4), .done(done4), .halted(halted4), .timeout(timeout4), .overflow(overflow4),
    .entries(entries4), .cycle_count(cycle_count4));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rout;
    logic [1:0]  fl;
  } ent_t;

  int          m_state = 0;
  int unsigned m_cyc = 0;
  bit          m_halted = 0, m_to = 0, m_ovf = 0, m_rv = 0;
  ent_t        m_rd = '0;
  ent_t        m_q[$];
  logic [31:0] m_pch[$];

  always @(posedge clk or posedge reset) begin
    bit   run, hit;
    ent_t e;
    if (reset) begin
      m_state = 0; m_cyc = 0; m_halted = 0; m_to = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
      m_q.delete(); m_pch.delete();
    end else begin
      run  = (m_state == 1);
      m_rv = !run && rd_req;
      if (m_rv) m_rd = (int'(rd_idx) < m_q.size()) ? m_q[rd_idx] : '0;
      if (!run && start) begin
        m_state = 1; m_cyc = 0; m_halted = 0; m_to = 0; m_ovf = 0;
        m_q.delete(); m_pch.delete();
      end else if (run) begin
        m_cyc++;
        m_pch.push_back(pc_i);
        if (STORE_ALL || mem_read_i || mem_write_i) begin
          if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
          e.pc = pc_i; e.alu = alu_i; e.rout = rout_i; e.fl = {mem_write_i, mem_read_i};
          m_q.push_back(e);
        end
        // halt = the last HR captured PCs of this run are all the same
        hit = (m_pch.size() >= HR);
        for (int k = 1; k < HR; k++)
          if (hit && m_pch[m_pch.size()-1-k] != pc_i) hit = 0;
        m_halted = hit;
        m_to     = (m_cyc == MAXC);
        if (hit || m_to) m_state = 2;
      end
    end
  end

  // ---------------- checking ----------------
  int n_pass = 0, n_tot = 0;

  task automatic cmp_cycle();
    bit ok;
    n_tot++;
    ok = (state_o === 2'(m_state)) && (done === (m_state == 2)) && (halted === m_halted) &&
         (timeout === m_to) && (overflow === m_ovf) && (entries === (AW+1)'(m_q.size())) &&
         (cycle_count === m_cyc) && (rd_valid === m_rv);
    if (m_rv && {rd_pc, rd_alu, rd_rout, rd_flags} !== m_rd) ok = 0;
    if (ok) n_pass++;
    else $display("FAIL cycle t=%0t: st=%0d/%0d hlt=%0b/%0b to=%0b/%0b ovf=%0b/%0b ent=%0d/%0d cyc=%0d/%0d rv=%0b/%0b pc=%h/%h fl=%b/%b",
                  $time, state_o, m_state, halted, m_halted, timeout, m_to, overflow, m_ovf,
                  entries, m_q.size(), cycle_count, m_cyc, rd_valid, m_rv, rd_pc, m_rd.pc, rd_flags, m_rd.fl);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    #1;
  endtask

  task automatic drv(input logic [31:0] pc, input bit mr, input bit mw);
    pc_i = pc; alu_i = pc ^ 32'h5A5A_0000; rout_i = pc + 32'h100;
    mem_read_i = mr; mem_write_i = mw;
  endtask

  logic [31:0] t2_pcs [8] = '{32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC, 32'hC};

  initial begin
    bit stb;
    tick(); tick();
    chk("reset_state", {state_o, done, halted, timeout, overflow, entries, cycle_count, rd_valid}, '0);
    reset = 0; tick();

    // budget-terminated run with PC stepping by 4 from 0
    start = 1; drv(32'h0, 0, 0); tick(); start = 0;
    for (int i = 0; i < 45; i++) begin drv(32'(4*i), 0, 0); tick(); end
    chk("t1_timeout", timeout, 1);
    chk("t1_halted", halted, 0);
    chk("t1_cycles", cycle_count, 40);
    rd_req = 1; rd_idx = 0; tick();
    chk("t1_rd0_valid", rd_valid, 1);
`ifdef TRACE_MEM_FILTER_EN
    chk("t1_entries", entries, 0);
    chk("t1_rd0_pc", rd_pc, 32'h0);
    rd_idx = 7; tick();
    chk("t1_rd7_pc", rd_pc, 32'h0);
`else
    chk("t1_entries", entries, 8);
    chk("t1_overflow", overflow, 1);
    chk("t1_rd0_pc", rd_pc, 32'h80);
    rd_idx = 7; tick();
    chk("t1_rd7_pc", rd_pc, 32'h9C);
`endif
    rd_req = 0; tick();
    chk("t1_rd_pulse_end", rd_valid, 0);

    // restart from DONE; PC settles at 0xC and the run halts
    start = 1; drv(32'h0, 0, 0); tick(); start = 0;
    chk("t2_restart", {state_o, halted, timeout, overflow}, {2'd1, 3'b000});
    rd_req = 1; rd_idx = 0;
    for (int i = 0; i < 8; i++) begin
      drv(t2_pcs[i], 0, 0); tick();
      if (i == 1) begin chk("t2_no_rd_in_run", rd_valid, 0); rd_req = 0; end
    end
    chk("t2_halted", halted, 1);
    chk("t2_timeout", timeout, 0);
    chk("t2_cycles", cycle_count, 6);
    rd_req = 1; rd_idx = 6; tick();
    chk("t2_rd6_oob", {rd_valid, rd_pc, rd_flags}, {1'b1, 32'h0, 2'b00});
`ifndef TRACE_MEM_FILTER_EN
    chk("t2_entries", entries, 6);
    rd_idx = 0; tick();
    chk("t2_rd0_pc", rd_pc, 32'h4);
`endif
    rd_req = 0; tick();

    // reset in the middle of a run
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) begin drv(32'h200 + 32'(4*i), 0, 0); tick(); end
    reset = 1; tick();
    chk("t3_rst_state", state_o, 0);
    chk("t3_rst_cycles", cycle_count, 0);
    chk("t3_rst_flags", {done, halted, timeout, overflow, entries}, '0);
    reset = 0; tick();

    // MAX_CYCLES=4 with PC held: halt and budget on the same edge
    start4 = 1; drv(32'h10, 0, 0); tick(); start4 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_both", {state4, halted4, timeout4}, {2'd2, 2'b11});
    chk("t4_cycles", cycle_count4, 4);

    // memory strobes on 5 of 40 cycles; a start in RUN must be ignored
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40; i++) begin
      stb = (i == 3) || (i == 9) || (i == 17) || (i == 25) || (i == 33);
      drv(32'h1000 + 32'(4*i), stb && (i < 20), stb && (i >= 20));
      start = (i == 20);
      tick();
    end
    start = 0; drv(32'h0, 0, 0); tick();
    chk("t5_cycles", cycle_count, 40);
    chk("t5_timeout", timeout, 1);
`ifdef TRACE_MEM_FILTER_EN
    chk("t5_entries", entries, 5);
`else
    chk("t5_entries", entries, 8);
`endif
    rd_req = 1;
    for (int k = 0; k < 5; k++) begin
      rd_idx = AW'(k); tick();
`ifdef TRACE_MEM_FILTER_EN
      chk("t5_rd_flags", rd_flags, (k < 3) ? 2'b01 : 2'b10);
`endif
    end
    rd_req = 0; tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
